// File: rtl/alien_fleet_if.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet_if
//  Description : Bundle between the game core (master) and the alien
//                formation controller (slave): game control and ship rocket
//                inputs, fleet position, hit and status outputs, alien fire.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alien_fleet_if #(
    parameter int N = 8
);
    // core -> fleet
    logic        playing;
    logic        tick;
    logic        rocket_flying;
    logic [9:0]  rocketX;
    logic [8:0]  rocketY;
    logic [8:0]  land_y;
    // fleet -> core
    logic [9:0]  fleetX;
    logic [8:0]  fleetY;
    logic [N-1:0] alive;
    logic        alien_hit;
    logic [2:0]  hit_index;
    logic        all_dead;
    logic        landed;
    logic        fire_req;
    logic [9:0]  fireX;
    logic [8:0]  fireY;

    modport master (
        output playing, tick, rocket_flying, rocketX, rocketY, land_y,
        input  fleetX, fleetY, alive, alien_hit, hit_index, all_dead, landed,
               fire_req, fireX, fireY
    );

    modport slave (
        input  playing, tick, rocket_flying, rocketX, rocketY, land_y,
        output fleetX, fleetY, alive, alien_hit, hit_index, all_dead, landed,
               fire_req, fireX, fireY
    );
endinterface
`default_nettype wire

// File: rtl/alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet
//  Description : Formation controller for the ROWS x COLS alien grid. Marches
//                the fleet sideways, drops a row at the screen edges,
//                resolves ship-rocket hits and reports cleared / landed.
//                Optional alien fire scheduler: define ALIEN_FLEET_FIRE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_fleet #(
    parameter int COLS        = 4,
    parameter int ROWS        = 2,
    parameter int X0          = 30,
    parameter int Y0          = 50,
    parameter int XSTEP       = 30,
    parameter int YSTEP       = 50,
    parameter int HALFW       = 20,
    parameter int HALFH       = 10,
    parameter int XMIN        = 0,
    parameter int XMAX        = 620,
    parameter int STEP        = 4,
    parameter int DROP        = 10,
    parameter int MOVE_DIV    = 8,
    parameter int FIRE_PERIOD = 64
) (
    input  logic           clk,
    input  logic           reset,      // asynchronous, active-low
    alien_fleet_if.slave   bus
);
    localparam int N  = ROWS * COLS;
    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MARCH   = 3'd1;
    localparam logic [2:0] S_DROP    = 3'd2;
    localparam logic [2:0] S_CLEARED = 3'd3;
    localparam logic [2:0] S_LANDED  = 3'd4;

    // Geometry is evaluated in 11 bits so no sum or compare can wrap.
    localparam logic [10:0] c_XSTEP = 11'(XSTEP);
    localparam logic [10:0] c_YSTEP = 11'(YSTEP);
    localparam logic [10:0] c_HALFW = 11'(HALFW);
    localparam logic [10:0] c_HALFH = 11'(HALFH);
    localparam logic [10:0] c_XMIN  = 11'(XMIN);
    localparam logic [10:0] c_XMAX  = 11'(XMAX);
    localparam logic [10:0] c_STEP  = 11'(STEP);
    localparam logic [10:0] c_DROP  = 11'(DROP);

    logic [2:0]    state_q, state_d;
    logic [9:0]    fleet_x_q, fleet_x_d;
    logic [8:0]    fleet_y_q, fleet_y_d;
    logic [N-1:0]  alive_q, alive_d;
    logic          dir_q, dir_d;          // 0 = moving right, 1 = moving left
    logic [MW-1:0] move_cnt_q, move_cnt_d;
    logic          alien_hit_q, alien_hit_d;
    logic [2:0]    hit_index_q, hit_index_d;
    logic          all_dead_q, all_dead_d;
    logic          landed_q, landed_d;

    logic [10:0]   fx11, fy11, rx11, ry11;
    logic          hit_found;
    logic [2:0]    hit_idx;
    logic [10:0]   hit_ax, hit_ay, geo_ay;
    logic [COLS-1:0] col_alive;
    logic [10:0]   right_col, left_col;
    logic          land_hit;
    logic [10:0]   edge_r, edge_l;
    logic          move_evt;
    logic          can_move;

    assign fx11 = {1'b0, fleet_x_q};
    assign fy11 = {2'b0, fleet_y_q};
    assign rx11 = {1'b0, bus.rocketX};
    assign ry11 = {2'b0, bus.rocketY};

    // Rocket-vs-alien overlap; descending scan so the lowest index wins.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_ax    = '0;
        hit_ay    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            hit_ax = fx11 + 11'(i % COLS) * c_XSTEP;
            hit_ay = fy11 + 11'(i / COLS) * c_YSTEP;
            if (bus.rocket_flying && alive_q[i] &&
                (rx11 + c_HALFW >= hit_ax) && (rx11 <= hit_ax + c_HALFW) &&
                (ry11 + c_HALFH >= hit_ay) && (ry11 <= hit_ay + c_HALFH)) begin
                hit_found = 1'b1;
                hit_idx   = 3'(i);
            end
        end
    end

    // Occupied columns, outermost live columns and landing detection.
    always_comb begin
        col_alive = '0;
        land_hit  = 1'b0;
        geo_ay    = '0;
        right_col = '0;
        left_col  = '0;
        for (int i = 0; i < N; i++) begin
            geo_ay = fy11 + 11'(i / COLS) * c_YSTEP;
            if (alive_q[i]) begin
                col_alive[i % COLS] = 1'b1;
                if (geo_ay + c_HALFH >= {2'b00, bus.land_y}) begin
                    land_hit = 1'b1;
                end
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_alive[c]) right_col = 11'(c);
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_alive[c]) left_col = 11'(c);
        end
    end

    assign edge_r   = fx11 + right_col * c_XSTEP;
    assign edge_l   = fx11 + left_col * c_XSTEP;
    assign move_evt = bus.tick && (move_cnt_q == MW'(MOVE_DIV - 1));
    // Left test is rearranged so the subtraction can never underflow.
    assign can_move = dir_q ? (edge_l >= c_XMIN + c_HALFW + c_STEP)
                            : (edge_r + c_STEP <= c_XMAX - c_HALFW);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; losing playing overrides everything.
    always_comb begin
        state_d = state_q;
        if (!bus.playing) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_MARCH;
                S_MARCH: begin
                    if (alive_q == '0)              state_d = S_CLEARED;
                    else if (land_hit)              state_d = S_LANDED;
                    else if (move_evt && !can_move) state_d = S_DROP;
                end
                S_DROP: begin
                    if (alive_q == '0)  state_d = S_CLEARED;
                    else if (land_hit)  state_d = S_LANDED;
                    else                state_d = S_MARCH;
                end
                S_CLEARED: state_d = S_CLEARED;
                S_LANDED:  state_d = S_LANDED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values. A move still commits in the cycle a
    // landing is detected; the freeze takes effect from the next state on.
    always_comb begin
        fleet_x_d   = fleet_x_q;
        fleet_y_d   = fleet_y_q;
        alive_d     = alive_q;
        dir_d       = dir_q;
        move_cnt_d  = move_cnt_q;
        alien_hit_d = 1'b0;
        hit_index_d = hit_index_q;
        all_dead_d  = (state_d == S_CLEARED);
        landed_d    = (state_d == S_LANDED);
        if (!bus.playing || state_q == S_IDLE) begin
            fleet_x_d  = 10'(X0);
            fleet_y_d  = 9'(Y0);
            alive_d    = '1;
            dir_d      = 1'b0;
            move_cnt_d = '0;
        end else if (state_q == S_MARCH || state_q == S_DROP) begin
            if (hit_found) begin
                alive_d[hit_idx] = 1'b0;
                alien_hit_d      = 1'b1;
                hit_index_d      = hit_idx;
            end
            if (state_q == S_MARCH && bus.tick) begin
                move_cnt_d = move_evt ? '0 : move_cnt_q + MW'(1);
                if (move_evt && can_move) begin
                    fleet_x_d = dir_q ? 10'(fx11 - c_STEP) : 10'(fx11 + c_STEP);
                end
            end
            if (state_q == S_DROP) begin
                fleet_y_d = 9'(fy11 + c_DROP);
                dir_d     = ~dir_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fleet_x_q   <= 10'(X0);
            fleet_y_q   <= 9'(Y0);
            alive_q     <= '1;
            dir_q       <= 1'b0;
            move_cnt_q  <= '0;
            alien_hit_q <= 1'b0;
            hit_index_q <= '0;
            all_dead_q  <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            fleet_x_q   <= fleet_x_d;
            fleet_y_q   <= fleet_y_d;
            alive_q     <= alive_d;
            dir_q       <= dir_d;
            move_cnt_q  <= move_cnt_d;
            alien_hit_q <= alien_hit_d;
            hit_index_q <= hit_index_d;
            all_dead_q  <= all_dead_d;
            landed_q    <= landed_d;
        end
    end

    assign bus.fleetX    = fleet_x_q;
    assign bus.fleetY    = fleet_y_q;
    assign bus.alive     = alive_q;
    assign bus.alien_hit = alien_hit_q;
    assign bus.hit_index = hit_index_q;
    assign bus.all_dead  = all_dead_q;
    assign bus.landed    = landed_q;

`ifdef ALIEN_FLEET_FIRE_EN
    localparam int FW = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;

    logic [7:0]    lfsr_q, lfsr_d;
    logic [FW-1:0] fire_cnt_q, fire_cnt_d;
    logic          fire_req_q, fire_req_d;
    logic [9:0]    fire_x_q, fire_x_d;
    logic [8:0]    fire_y_q, fire_y_d;
    logic [10:0]   fire_col, fire_row;
    logic          fire_found;

    // Lowest (largest row index) alive alien in the LFSR-chosen column.
    always_comb begin
        fire_col   = 11'(lfsr_q) % 11'(COLS);
        fire_found = 1'b0;
        fire_row   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (alive_q[r * COLS + int'(fire_col)]) begin
                fire_found = 1'b1;
                fire_row   = 11'(r);
            end
        end
    end

    // LFSR x^8+x^6+x^5+x^4+1 stepped per march tick; fire once per period.
    always_comb begin
        lfsr_d     = lfsr_q;
        fire_cnt_d = fire_cnt_q;
        fire_req_d = 1'b0;
        fire_x_d   = fire_x_q;
        fire_y_d   = fire_y_q;
        if (!bus.playing || state_q == S_IDLE) begin
            lfsr_d     = 8'hA5;
            fire_cnt_d = '0;
        end else if (state_q == S_MARCH && bus.tick) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (fire_cnt_q == FW'(FIRE_PERIOD - 1)) begin
                fire_cnt_d = '0;
                if (fire_found) begin
                    fire_req_d = 1'b1;
                    fire_x_d   = 10'(fx11 + fire_col * c_XSTEP);
                    fire_y_d   = 9'(fy11 + fire_row * c_YSTEP + c_HALFH);
                end
            end else begin
                fire_cnt_d = fire_cnt_q + FW'(1);
            end
        end
    end

    // Fire scheduler registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q     <= 8'hA5;
            fire_cnt_q <= '0;
            fire_req_q <= 1'b0;
            fire_x_q   <= '0;
            fire_y_q   <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            fire_cnt_q <= fire_cnt_d;
            fire_req_q <= fire_req_d;
            fire_x_q   <= fire_x_d;
            fire_y_q   <= fire_y_d;
        end
    end

    assign bus.fire_req = fire_req_q;
    assign bus.fireX    = fire_x_q;
    assign bus.fireY    = fire_y_q;
`else
    assign bus.fire_req = 1'b0;
    assign bus.fireX    = '0;
    assign bus.fireY    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_fleet
//  Description : Self-checking bench for alien_fleet. Expected hit indices
//                are queued as rockets are launched and popped on each
//                alien_hit pulse; state checks use fixed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_fleet;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alien_fleet_if #(.N(8)) bus();

    alien_fleet dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_q[$];
    int         fire_cnt = 0;
    logic [9:0] fire_x_seen = '0;
    logic [8:0] fire_y_seen = '0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every hit pulse must match the oldest queued target.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.alien_hit) begin
                if (exp_q.size() == 0)
                    check_value("hit_unexpected", 32'(bus.alien_hit), 32'd0);
                else
                    check_value("hit_index", 32'(bus.hit_index), 32'(exp_q.pop_front()));
            end
            if (bus.fire_req) begin
                fire_cnt++;
                fire_x_seen = bus.fireX;
                fire_y_seen = bus.fireY;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) step();
        bus.tick = 1'b0;
    endtask

    // Rocket centred on alien idx for one sampled cycle (fleet at reset spot).
    task automatic kill(input int idx);
        bus.rocketX       = 10'(30 + 30 * (idx % 4));
        bus.rocketY       = 9'(50 + 50 * (idx / 4));
        bus.rocket_flying = 1'b1;
        exp_q.push_back(idx);
        step();
        bus.rocket_flying = 1'b0;
    endtask

    initial begin
        reset             = 1'b0;
        bus.playing       = 1'b0;
        bus.tick          = 1'b0;
        bus.rocket_flying = 1'b0;
        bus.rocketX       = '0;
        bus.rocketY       = '0;
        bus.land_y        = 9'd511;
        repeat (3) step();
        reset = 1'b1;
        step();
        step();

        check_value("rst_fleetX",   32'(bus.fleetX),    32'd30);
        check_value("rst_fleetY",   32'(bus.fleetY),    32'd50);
        check_value("rst_alive",    32'(bus.alive),     32'hFF);
        check_value("rst_hit",      32'(bus.alien_hit), 32'd0);
        check_value("rst_hit_idx",  32'(bus.hit_index), 32'd0);
        check_value("rst_all_dead", 32'(bus.all_dead),  32'd0);
        check_value("rst_landed",   32'(bus.landed),    32'd0);
        check_value("rst_fire_req", 32'(bus.fire_req),  32'd0);
        check_value("rst_fireX",    32'(bus.fireX),     32'd0);
        check_value("rst_fireY",    32'(bus.fireY),     32'd0);

        bus.playing = 1'b1;
        step();

        // Rocket held on alien 5 for three cycles: exactly one pulse.
        bus.rocketX       = 10'd60;
        bus.rocketY       = 9'd100;
        bus.rocket_flying = 1'b1;
        exp_q.push_back(5);
        repeat (3) step();
        bus.rocket_flying = 1'b0;
        step();
        check_value("alive_after5", 32'(bus.alive), 32'hDF);

        kill(0);
        step();
        kill(2);
        step();
        check_value("alive_3kills", 32'(bus.alive), 32'hDA);
        do_ticks(16);
        check_value("march_x38", 32'(bus.fleetX), 32'd38);

        // Dropping playing reloads the formation.
        bus.playing = 1'b0;
        step();
        check_value("idle_fleetX", 32'(bus.fleetX), 32'd30);
        check_value("idle_fleetY", 32'(bus.fleetY), 32'd50);
        check_value("idle_alive",  32'(bus.alive),  32'hFF);

        // Full march to the right edge, drop, then one move left.
        bus.playing = 1'b1;
        step();
        do_ticks(960);
        check_value("edge_fleetX", 32'(bus.fleetX), 32'd510);
        check_value("edge_fleetY", 32'(bus.fleetY), 32'd50);
        do_ticks(8);
        check_value("drop_hold_x", 32'(bus.fleetX), 32'd510);
        step();
        check_value("drop_fleetY", 32'(bus.fleetY), 32'd60);
        check_value("drop_fleetX", 32'(bus.fleetX), 32'd510);
        do_ticks(8);
        check_value("left_fleetX", 32'(bus.fleetX), 32'd506);

        // Landing boundary: lowest alien bottom edge is 60+50+10 = 120.
        bus.land_y = 9'd121;
        step();
        step();
        check_value("no_land_121", 32'(bus.landed), 32'd0);
        bus.land_y = 9'd120;
        step();
        check_value("land_120", 32'(bus.landed), 32'd1);
        do_ticks(16);
        check_value("land_frozen_x", 32'(bus.fleetX), 32'd506);
        check_value("land_frozen_y", 32'(bus.fleetY), 32'd60);

        bus.playing = 1'b0;
        step();
        check_value("land_cleared", 32'(bus.landed), 32'd0);
        bus.land_y  = 9'd511;
        bus.playing = 1'b1;
        step();

        // Clear the whole fleet; all_dead arrives two cycles after last kill.
        for (int i = 0; i < 7; i++) begin
            kill(i);
            step();
        end
        kill(7);
        check_value("alive_zero",     32'(bus.alive),    32'h00);
        check_value("all_dead_early", 32'(bus.all_dead), 32'd0);
        step();
        check_value("all_dead_set",   32'(bus.all_dead), 32'd1);
        do_ticks(16);
        check_value("clear_frozen_x", 32'(bus.fleetX),   32'd30);
        check_value("clear_frozen_y", 32'(bus.fleetY),   32'd50);
        check_value("all_dead_hold",  32'(bus.all_dead), 32'd1);

`ifdef ALIEN_FLEET_FIRE_EN
        begin
            logic [7:0] l;
            int         col;
            bus.playing = 1'b0;
            step();
            bus.playing = 1'b1;
            step();
            fire_cnt = 0;
            l = 8'hA5;
            repeat (63) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
            col = int'(l) % 4;
            do_ticks(64);
            step();
            check_value("fire_count", 32'(fire_cnt), 32'd1);
            // Seven moves have committed before the firing tick: 30 + 28.
            check_value("fire_x", 32'(fire_x_seen), 32'(58 + 30 * col));
            check_value("fire_y", 32'(fire_y_seen), 32'd110);
        end
`else
        check_value("fire_none",    32'(fire_cnt),     32'd0);
        check_value("fire_req_low", 32'(bus.fire_req), 32'd0);
`endif

        check_value("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alien_fleet.md
# alien_fleet

Formation controller for the 2×4 alien grid. It marches the fleet left and right and drops it one row at each screen edge. It resolves ship-rocket collisions against each alive alien and, optionally, schedules alien rocket launches. It sits upstream of the game core: it feeds alien positions, hit pulses, clear/landed status and fire requests to the core's game FSM, VGA painter and alien rocket instances.

## Interface
- COLS, 4, aliens per row
- ROWS, 2, rows; alien count N = ROWS*COLS (8)
- X0, 30, reset fleetX (centre of column 0)
- Y0, 50, reset fleetY (centre of row 0)
- XSTEP, 30, column pitch in px
- YSTEP, 50, row pitch in px
- HALFW, 20, alien half-width
- HALFH, 10, alien half-height
- XMIN, 0, left screen limit
- XMAX, 620, right screen limit
- STEP, 4, horizontal px per move
- DROP, 10, px per drop
- MOVE_DIV, 8, ticks per move
- FIRE_PERIOD, 64, ticks between fire attempts
- clk  in  1  game clock
- reset  in  1  asynchronous, active-low reset
- playing  in  1  game-active level from core FSM
- tick  in  1  one-cycle game-step enable
- rocket_flying  in  1  ship rocket valid
- rocketX  in  10  ship rocket centre X
- rocketY  in  9  ship rocket centre Y
- land_y  in  9  ship top edge; landing threshold
- fleetX  out  10  centre X of alien 0
- fleetY  out  9  centre Y of alien 0
- alive  out  N  per-alien alive bits; index = row*COLS+col
- alien_hit  out  1  one-cycle hit pulse
- hit_index  out  3  index of the alien hit; valid with alien_hit
- all_dead  out  1  fleet cleared
- landed  out  1  fleet reached land_y
- fire_req  out  1  one-cycle alien rocket launch
- fireX  out  10  launch X
- fireY  out  9  launch Y

## Operation
- Alien i position: X = fleetX + col*XSTEP, Y = fleetY + row*YSTEP. All arithmetic is unsigned; compares are done in 11 bits so there is no wrap.
- States:
  - IDLE: positions reloaded (X0, Y0), alive all ones, direction right, counters cleared. Go to MARCH when playing=1.
  - MARCH: the move counter advances on each tick; at MOVE_DIV-1 it wraps and a move event occurs.
    - If the next step keeps the outermost alive column within [XMIN+HALFW, XMAX-HALFW], fleetX ± STEP.
    - Otherwise go to DROP.
  - DROP: single cycle. fleetY += DROP, direction inverts, return to MARCH.
  - CLEARED: entered when alive becomes 0. all_dead=1. Frozen.
  - LANDED: entered when any alive alien satisfies Y+HALFH ≥ land_y. landed=1. Frozen.
- From any state, playing=0 → IDLE on the next cycle.
- Hit check runs every cycle in MARCH/DROP with rocket_flying=1.
  - Alien i is hit when alive[i], rocketX+HALFW ≥ X, rocketX ≤ X+HALFW, rocketY+HALFH ≥ Y and rocketY ≤ Y+HALFH.
  - Lowest hit index wins; at most one kill per cycle.
  - The winner's alive bit clears, alien_hit pulses and hit_index is set.
- tick is ignored in IDLE, CLEARED and LANDED.

## Timing
- Reset values: fleetX=X0, fleetY=Y0, alive=all ones, alien_hit=0, hit_index=0, all_dead=0, landed=0, fire_req=0, fireX=0, fireY=0, state IDLE.
- All outputs are registered.
- alien_hit and the alive update appear one cycle after the overlapping inputs are sampled.
- Hit check uses pre-move positions when a hit and a move fall in the same cycle.
- A kill of the last alien in cycle t gives all_dead=1 at t+2. That kill's alien_hit still pulses.
- A move and a landing in the same cycle: the move commits and LANDED is taken next cycle.
- A rocket held on an alien produces one pulse only, because the alive bit is already cleared.

## Configuration
- ALIEN_FLEET_FIRE_EN defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances each tick in MARCH.
  - Every FIRE_PERIOD ticks the column is lfsr mod COLS.
  - If that column holds an alive alien, fire_req pulses for one cycle, with fireX = X and fireY = Y+HALFH of the lowest alive alien in it.
  - If the column is empty, there is no fire that period.
- Undefined: the LFSR and fire counter are absent; fire_req, fireX and fireY are tied to 0.

## Test plan
- Release reset with playing=0 → fleetX=30, fleetY=50, alive=8'hFF, all flags 0. Set playing=1 → MARCH next cycle.
- Apply ticks continuously with all alive → fleetX steps by 4 every 8 ticks up to 510. The 121st move event drops: fleetY=60 and the direction goes left.
- At reset positions drive rocket (60,100) with rocket_flying=1 → alien_hit pulses once, hit_index=5, alive=8'hDF.
- Kill all 8 aliens in sequence → 8 pulses, all_dead=1, and positions freeze under further ticks.
- Drop playing mid-march after 3 kills → IDLE next cycle; fleetX=30, fleetY=50, alive=8'hFF.
- With ALIEN_FLEET_FIRE_EN, after FIRE_PERIOD ticks the column is LFSR-chosen → fire_req pulses with fireY=110 from row 1. Empty column → no pulse. With the macro undefined, fire_req stays 0.
